msg_router_arbiter: RTL and testbench
=====================================

Name: msg_router_arbiter

Overview:
- Shares one message-network injection port among NUM_REQ local requesters using round-robin arbitration.
- Forms the outgoing tagged message {address, requester tag} and holds it until the network accepts it.
- Demultiplexes tagged responses back to the owning requester.
- Sits between the processor request ports and the message router. Each requester may have at most one transaction outstanding.

Parameters:
- NUM_REQ, 4, number of requesters; must satisfy NUM_REQ <= 2**PROC_BITS (elaboration-time check).
- PROC_BITS, 4, width of the tag field, carried in the message LSBs.
- DATA_SIZE, 32, width of the address/data payload.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- req_valid_in  input  NUM_REQ  per-requester request valid
- req_addr_in  input  NUM_REQ x DATA_SIZE  per-requester request address
- req_ready_out  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
- msg_valid_out  output  1  outgoing message valid
- msg_out  output  DATA_SIZE+PROC_BITS  {addr, tag}; tag in bits [PROC_BITS-1:0]
- msg_ready_in  input  1  network accepts msg_out this cycle
- resp_valid_in  input  1  tagged response valid, single-cycle, no backpressure
- resp_in  input  DATA_SIZE+PROC_BITS  {data, tag}
- resp_valid_out  output  NUM_REQ  registered one-hot response strobe
- resp_data_out  output  DATA_SIZE  registered response payload
- pending_out  output  NUM_REQ  outstanding-transaction bit per requester
- drop_err_out  output  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, pending=0, msg_valid_out=0, msg_out=0, req_ready_out=0, resp_valid_out=0, resp_data_out=0, drop_err_out=0. Reset asserted mid-transaction discards the held message; no response is delivered for it.
- Eligibility: eligible[i] = req_valid_in[i] & ~pending[i], using the pending value registered at the start of the cycle.
- Winner selection: the first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
- States: IDLE and SEND.
- IDLE, with any eligible requester and winner w:
  - req_ready_out[w]=1 combinationally in this cycle.
  - Register msg_out={req_addr_in[w], w zero-extended to PROC_BITS}.
  - Set pending[w].
  - rr_ptr <= (w+1) mod NUM_REQ.
  - Go to SEND.
- SEND: msg_valid_out=1, and msg_out holds stable until msg_ready_in=1.
  - On accept with an eligible requester: grant it in the same cycle, reload msg_out, stay in SEND. This gives back-to-back one message per cycle.
  - On accept with none eligible: go to IDLE.
- Latency: request accepted in cycle N; msg_valid_out=1 from cycle N+1.
- Response path, when resp_valid_in=1 with tag t=resp_in[PROC_BITS-1:0]:
  - If t<NUM_REQ and pending[t]=1: next cycle resp_valid_out[t]=1 and resp_data_out=resp_in[DATA_SIZE+PROC_BITS-1:PROC_BITS]; clear pending[t].
  - Otherwise (t>=NUM_REQ or pending[t]=0): drop the response and set drop_err_out. drop_err_out clears only on reset.
- resp_valid_out is 0 in every cycle without a preceding valid response.
- Simultaneous response clear and grant on the same index: the requester is not eligible in that cycle (it uses the old pending value); it becomes eligible in the next cycle.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: MSG_ROUTER_ARB_PERF_EN.
- Defined: adds output grant_count_out (32 bits). It increments on every message accepted by the network (msg_valid_out & msg_ready_in), resets to 0, and saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package msg_router_pkg holds:
  - the arb_state_t enum {IDLE, SEND};
  - the tag extract/insert width constants;
  - a function for building the {addr, tag} message.
- One sub-module, rr_priority_pick: combinational round-robin picker taking eligible[NUM_REQ] and rr_ptr, returning winner index and any_valid.

Test Plan:
- Reset, then req_valid_in=4'b0001, addr 0x1000 -> req_ready_out[0] pulses once; next cycle msg_out={0x1000, 4'h0}, msg_valid_out=1; held stable through 3 cycles of msg_ready_in=0.
- All four requesters valid, msg_ready_in=1 continuously -> grants in order 0,1,2,3 on consecutive cycles; no further grants until responses return.
- Response {0xDEADBEEF, 4'h2} with pending[2]=1 -> one cycle later resp_valid_out=4'b0100, resp_data_out=0xDEADBEEF; pending[2] clears.
- Response with tag 4'h7 (NUM_REQ=4), and separately tag 1 with pending[1]=0 -> no resp_valid_out; drop_err_out=1 and stays 1.
- rst_in asserted while in SEND with msg_ready_in=0 -> next cycle msg_valid_out=0, pending=0, rr_ptr=0.
- With MSG_ROUTER_ARB_PERF_EN defined: 10 network accepts -> grant_count_out=10.

Source files
------------

// File: rtl/msg_router_pkg.sv
// ---------------------------------------------------------------------------
// msg_router_pkg
// Shared types, constants and helpers for the message-router arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SEND)
//   ADDR_W_MAX / TAG_W_MAX / MSG_W_MAX : widest address and tag fields the
//                 message builder handles; the top truncates the result to
//                 its own DATA_SIZE+PROC_BITS width.
//   build_msg() : assembles {addr, tag} with the tag in the low tag_bits.
// ---------------------------------------------------------------------------
package msg_router_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  localparam int unsigned ADDR_W_MAX = 64;
  localparam int unsigned TAG_W_MAX  = 16;
  localparam int unsigned MSG_W_MAX  = ADDR_W_MAX + TAG_W_MAX;

  // Tag occupies bits [tag_bits-1:0]; address sits directly above it.
  // Any tag bits above tag_bits are masked off so they cannot leak into
  // the address field.
  function automatic logic [MSG_W_MAX-1:0] build_msg(
    input logic [ADDR_W_MAX-1:0] addr,
    input logic [TAG_W_MAX-1:0]  tag,
    input int                    tag_bits
  );
    logic [MSG_W_MAX-1:0] tag_keep;
    tag_keep  = ~({MSG_W_MAX{1'b1}} << tag_bits);
    build_msg = ({{TAG_W_MAX{1'b0}}, addr} << tag_bits) |
                ({{ADDR_W_MAX{1'b0}}, tag} & tag_keep);
  endfunction

endpackage

// File: rtl/msg_router_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. Scans eligible starting at rr_ptr and
// wrapping modulo NUM_REQ; the first set bit wins.
//   eligible  : per-requester eligibility vector
//   rr_ptr    : index with highest priority this cycle
//   winner    : selected index (0 when nothing is eligible)
//   any_valid : at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  // Walk the offsets from the far end back to rr_ptr so the last hit
  // recorded is the one closest to rr_ptr, i.e. the highest priority.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = SUM_W'(rr_ptr) + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (eligible[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_router_arbiter.sv
// ---------------------------------------------------------------------------
// msg_router_arbiter
// Shares one message-network injection port among NUM_REQ requesters with
// round-robin arbitration, holds the tagged message {addr, tag} until the
// network takes it, and routes tagged responses back to their owner.
//
// Ports:
//   clk_in, rst_in   : clock, synchronous active-high reset
//   req_valid_in     : per-requester request valid
//   req_addr_in      : per-requester request address
//   req_ready_out    : one-hot accept pulse to the granted requester
//   msg_valid_out    : outgoing message valid
//   msg_out          : {addr, tag}, tag in [PROC_BITS-1:0]
//   msg_ready_in     : network accepts msg_out this cycle
//   resp_valid_in    : tagged response valid (single cycle)
//   resp_in          : {data, tag}
//   resp_valid_out   : registered one-hot response strobe
//   resp_data_out    : registered response payload
//   pending_out      : outstanding-transaction bit per requester
//   grant_count_out  : accepted-message counter (MSG_ROUTER_ARB_PERF_EN only)
//   drop_err_out     : sticky flag for dropped (unmatched) responses
//
// Build option: define MSG_ROUTER_ARB_PERF_EN to add grant_count_out, a
// saturating 32-bit count of messages accepted by the network.
// ---------------------------------------------------------------------------
module msg_router_arbiter
  import msg_router_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PROC_BITS = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]                  req_ready_out,
  output logic                                msg_valid_out,
  output logic [DATA_SIZE+PROC_BITS-1:0]      msg_out,
  input  logic                                msg_ready_in,
  input  logic                                resp_valid_in,
  input  logic [DATA_SIZE+PROC_BITS-1:0]      resp_in,
  output logic [NUM_REQ-1:0]                  resp_valid_out,
  output logic [DATA_SIZE-1:0]                resp_data_out,
  output logic [NUM_REQ-1:0]                  pending_out,
`ifdef MSG_ROUTER_ARB_PERF_EN
  output logic [31:0]                         grant_count_out,
`endif
  output logic                                drop_err_out
);

  localparam int MSG_W = DATA_SIZE + PROC_BITS;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (NUM_REQ > (1 << PROC_BITS) || PROC_BITS > int'(TAG_W_MAX) ||
        DATA_SIZE > int'(ADDR_W_MAX)) begin : g_bad_cfg
      $error("msg_router_arbiter: NUM_REQ must fit in PROC_BITS tag bits");
    end
  endgenerate

  arb_state_t             state_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [NUM_REQ-1:0]     pending_reg;
  logic                   msg_valid_reg;
  logic [MSG_W-1:0]       msg_reg;
  logic [NUM_REQ-1:0]     resp_valid_reg;
  logic [DATA_SIZE-1:0]   resp_data_reg;
  logic                   drop_err_reg;

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant_onehot;
  logic [NUM_REQ-1:0]     resp_hit;
  logic [IDX_W-1:0]       winner;
  logic                   any_eligible;
  logic                   grant_fire;
  logic [IDX_W-1:0]       rr_ptr_next;
  logic [PROC_BITS-1:0]   resp_tag;
  logic [DATA_SIZE-1:0]   resp_payload;
  logic                   resp_any_hit;

  assign resp_tag     = resp_in[PROC_BITS-1:0];
  assign resp_payload = resp_in[MSG_W-1:PROC_BITS];

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_reg),
    .winner    (winner),
    .any_valid (any_eligible)
  );

  // A new grant is possible whenever the output slot is free: either idle,
  // or the held message is leaving this cycle.
  assign grant_fire  = any_eligible && !rst_in &&
                       ((state_reg == IDLE) || msg_ready_in);
  assign rr_ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Per-requester decode. Comparing the tag against each index avoids
  // indexing pending with an out-of-range tag.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign eligible[gi]     = req_valid_in[gi] & ~pending_reg[gi];
      assign grant_onehot[gi] = grant_fire && (winner == IDX_W'(gi));
      assign resp_hit[gi]     = resp_valid_in && (resp_tag == PROC_BITS'(gi)) &&
                                pending_reg[gi];
    end
  endgenerate

  assign resp_any_hit = |resp_hit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      pending_reg    <= '0;
      msg_valid_reg  <= 1'b0;
      msg_reg        <= '0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      drop_err_reg   <= 1'b0;
    end else begin
      // A grant needs pending=0 and a clear needs pending=1, so the two can
      // never target the same bit in one cycle.
      pending_reg <= (pending_reg | grant_onehot) & ~resp_hit;

      if (grant_fire) begin
        msg_reg    <= MSG_W'(build_msg(ADDR_W_MAX'(req_addr_in[winner]),
                                       TAG_W_MAX'(winner), PROC_BITS));
        rr_ptr_reg <= rr_ptr_next;
      end

      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            state_reg     <= SEND;
            msg_valid_reg <= 1'b1;
          end
        end
        SEND: begin
          if (msg_ready_in && !grant_fire) begin
            state_reg     <= IDLE;
            msg_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          msg_valid_reg <= 1'b0;
        end
      endcase

      resp_valid_reg <= resp_hit;
      if (resp_any_hit) begin
        resp_data_reg <= resp_payload;
      end
      if (resp_valid_in && !resp_any_hit) begin
        drop_err_reg <= 1'b1;
      end
    end
  end

`ifdef MSG_ROUTER_ARB_PERF_EN
  logic [31:0] grant_count_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_count_reg <= '0;
    end else if (msg_valid_reg && msg_ready_in && (grant_count_reg != '1)) begin
      grant_count_reg <= grant_count_reg + 32'd1;
    end
  end

  assign grant_count_out = grant_count_reg;
`endif

  assign req_ready_out  = grant_onehot;
  assign msg_valid_out  = msg_valid_reg;
  assign msg_out        = msg_reg;
  assign resp_valid_out = resp_valid_reg;
  assign resp_data_out  = resp_data_reg;
  assign pending_out    = pending_reg;
  assign drop_err_out   = drop_err_reg;

endmodule

// File: tb/tb_msg_router_arbiter.sv
// ---------------------------------------------------------------------------
// tb_msg_router_arbiter
// Self-checking bench for msg_router_arbiter (NUM_REQ=4, PROC_BITS=4,
// DATA_SIZE=32). Expected messages and responses are queued when stimulus
// is driven and compared by monitors when the DUT emits them. Inputs are
// driven 1 time unit after posedge; outputs are sampled at/after negedge.
// ---------------------------------------------------------------------------
module tb_msg_router_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PROC_BITS = 4;
  localparam int DATA_SIZE = 32;
  localparam int MSG_W     = DATA_SIZE + PROC_BITS;

  logic                              clk_in;
  logic                              rst_in;
  logic [NUM_REQ-1:0]                req_valid_in;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_addr_in;
  logic [NUM_REQ-1:0]                req_ready_out;
  logic                              msg_valid_out;
  logic [MSG_W-1:0]                  msg_out;
  logic                              msg_ready_in;
  logic                              resp_valid_in;
  logic [MSG_W-1:0]                  resp_in;
  logic [NUM_REQ-1:0]                resp_valid_out;
  logic [DATA_SIZE-1:0]              resp_data_out;
  logic [NUM_REQ-1:0]                pending_out;
  logic                              drop_err_out;
`ifdef MSG_ROUTER_ARB_PERF_EN
  logic [31:0]                       grant_count_out;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [MSG_W-1:0]     exp_msg_q[$];
  logic [NUM_REQ-1:0]   exp_rv_q[$];
  logic [DATA_SIZE-1:0] exp_rd_q[$];

  msg_router_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .PROC_BITS (PROC_BITS),
    .DATA_SIZE (DATA_SIZE)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_addr_in     (req_addr_in),
    .req_ready_out   (req_ready_out),
    .msg_valid_out   (msg_valid_out),
    .msg_out         (msg_out),
    .msg_ready_in    (msg_ready_in),
    .resp_valid_in   (resp_valid_in),
    .resp_in         (resp_in),
    .resp_valid_out  (resp_valid_out),
    .resp_data_out   (resp_data_out),
    .pending_out     (pending_out),
`ifdef MSG_ROUTER_ARB_PERF_EN
    .grant_count_out (grant_count_out),
`endif
    .drop_err_out    (drop_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  // Message monitor: every network accept must match the oldest expected msg.
  always @(negedge clk_in) begin
    logic [MSG_W-1:0] em;
    if (mon_en && !rst_in && msg_valid_out === 1'b1 && msg_ready_in === 1'b1) begin
      checks++;
      if (exp_msg_q.size() == 0) begin
        errors++;
        $display("FAIL msg_accept: got %h, required no message", msg_out);
      end else begin
        em = exp_msg_q.pop_front();
        if (msg_out !== em) begin
          errors++;
          $display("FAIL msg_accept: got %h, required %h", msg_out, em);
        end else begin
          $display("msg accepted %h", msg_out);
        end
      end
    end
  end

  // Response monitor: any non-zero strobe must match the oldest expected resp.
  always @(negedge clk_in) begin
    logic [NUM_REQ-1:0]   ev;
    logic [DATA_SIZE-1:0] ed;
    if (mon_en && resp_valid_out !== '0) begin
      checks++;
      if (exp_rv_q.size() == 0) begin
        errors++;
        $display("FAIL resp_out: got %b/%h, required no response", resp_valid_out, resp_data_out);
      end else begin
        ev = exp_rv_q.pop_front();
        ed = exp_rd_q.pop_front();
        if (resp_valid_out !== ev || resp_data_out !== ed) begin
          errors++;
          $display("FAIL resp_out: got %b/%h, required %b/%h", resp_valid_out, resp_data_out, ev, ed);
        end else begin
          $display("resp delivered %b %h", resp_valid_out, resp_data_out);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_in  = '0;
    req_addr_in   = '0;
    msg_ready_in  = 1'b0;
    resp_valid_in = 1'b0;
    resp_in       = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_in = 1'b1;
    idle_inputs();
    exp_msg_q.delete();
    exp_rv_q.delete();
    exp_rd_q.delete();
    repeat (cycles) step();
    rst_in = 1'b0;
  endtask

  // Drives a tagged response for one cycle; queues the delivery if it hits.
  task automatic drive_resp(input logic [PROC_BITS-1:0] tag,
                            input logic [DATA_SIZE-1:0] data, input bit hit);
    resp_valid_in = 1'b1;
    resp_in       = {data, tag};
    if (hit) begin
      exp_rv_q.push_back(NUM_REQ'(1) << tag);
      exp_rd_q.push_back(data);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle_inputs();
    step();
    step();
    sample();
    checks += 7;
    if (msg_valid_out !== 1'b0) begin errors++; $display("FAIL reset_msg_valid: got %b, required 0", msg_valid_out); end
    if (msg_out !== '0) begin errors++; $display("FAIL reset_msg_out: got %h, required 0", msg_out); end
    if (req_ready_out !== '0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready_out); end
    if (resp_valid_out !== '0) begin errors++; $display("FAIL reset_resp_valid: got %b, required 0", resp_valid_out); end
    if (resp_data_out !== '0) begin errors++; $display("FAIL reset_resp_data: got %h, required 0", resp_data_out); end
    if (pending_out !== '0) begin errors++; $display("FAIL reset_pending: got %b, required 0", pending_out); end
    if (drop_err_out !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b, required 0", drop_err_out); end
    $display("reset checked");
    step();
    rst_in = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_hold();
    logic [MSG_W-1:0] em;
    em = {32'h0000_1000, 4'h0};
    step();
    req_valid_in   = 4'b0001;
    req_addr_in[0] = 32'h0000_1000;
    sample();
    checks++;
    if (req_ready_out !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, required 0001", req_ready_out); end
    exp_msg_q.push_back(em);
    step();
    req_valid_in = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks += 3;
      if (msg_valid_out !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b, required 1", c, msg_valid_out); end
      if (msg_out !== em) begin errors++; $display("FAIL hold_msg[%0d]: got %h, required %h", c, msg_out, em); end
      if (req_ready_out !== '0) begin errors++; $display("FAIL hold_ready[%0d]: got %b, required 0", c, req_ready_out); end
      $display("hold cycle %0d msg %h", c, msg_out);
      step();
    end
    msg_ready_in = 1'b1;
    sample();
    step();
    msg_ready_in = 1'b0;
    sample();
    checks += 2;
    if (msg_valid_out !== 1'b0) begin errors++; $display("FAIL single_idle: got %b, required 0", msg_valid_out); end
    if (pending_out !== 4'b0001) begin errors++; $display("FAIL single_pending: got %b, required 0001", pending_out); end
    step();
    drive_resp(4'h0, 32'hCAFE_0001, 1'b1);
    step();
    resp_valid_in = 1'b0;
    sample();
    checks++;
    if (pending_out !== '0) begin errors++; $display("FAIL single_clear: got %b, required 0", pending_out); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] er;
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) req_addr_in[i] = 32'h0000_A000 + DATA_SIZE'(i);
    req_valid_in = 4'b1111;
    msg_ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      er = (k < NUM_REQ) ? (NUM_REQ'(1) << k) : '0;
      checks++;
      if (req_ready_out !== er) begin errors++; $display("FAIL b2b_grant[%0d]: got %b, required %b", k, req_ready_out, er); end
      $display("b2b cycle %0d grant %b", k, req_ready_out);
      if (k < NUM_REQ) exp_msg_q.push_back({32'h0000_A000 + DATA_SIZE'(k), PROC_BITS'(k)});
      step();
    end
    req_valid_in = '0;
    msg_ready_in = 1'b0;
    sample();
    checks += 2;
    if (pending_out !== 4'b1111) begin errors++; $display("FAIL b2b_pending: got %b, required 1111", pending_out); end
    if (msg_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b, required 0", msg_valid_out); end
    step();
    drive_resp(4'h2, 32'hDEAD_BEEF, 1'b1);
    step();
    drive_resp(4'h0, 32'h0000_0000, 1'b1);
    sample();
    checks++;
    if (pending_out !== 4'b1011) begin errors++; $display("FAIL resp2_pending: got %b, required 1011", pending_out); end
    step();
    drive_resp(4'h3, 32'h3333_3333, 1'b1);
    step();
    drive_resp(4'h1, 32'h1111_1111, 1'b1);
    step();
    resp_valid_in = 1'b0;
    sample();
    checks += 2;
    if (pending_out !== '0) begin errors++; $display("FAIL resp_all_pending: got %b, required 0", pending_out); end
    if (exp_rv_q.size() != 0) begin errors++; $display("FAIL resp_all_delivered: got %0d left, required 0", exp_rv_q.size()); end
  endtask

  task automatic test_drop();
    step();
    drive_resp(4'h7, 32'h7777_7777, 1'b0);
    step();
    resp_valid_in = 1'b0;
    sample();
    checks += 2;
    if (resp_valid_out !== '0) begin errors++; $display("FAIL drop7_resp: got %b, required 0", resp_valid_out); end
    if (drop_err_out !== 1'b1) begin errors++; $display("FAIL drop7_err: got %b, required 1", drop_err_out); end
    repeat (3) step();
    sample();
    checks++;
    if (drop_err_out !== 1'b1) begin errors++; $display("FAIL drop7_sticky: got %b, required 1", drop_err_out); end
    step();
    do_reset(1);
    sample();
    checks++;
    if (drop_err_out !== 1'b0) begin errors++; $display("FAIL drop_reset: got %b, required 0", drop_err_out); end
    step();
    drive_resp(4'h1, 32'h1234_5678, 1'b0);
    step();
    resp_valid_in = 1'b0;
    sample();
    checks += 2;
    if (resp_valid_out !== '0) begin errors++; $display("FAIL drop1_resp: got %b, required 0", resp_valid_out); end
    if (drop_err_out !== 1'b1) begin errors++; $display("FAIL drop1_err: got %b, required 1", drop_err_out); end
    $display("drop checked err=%b", drop_err_out);
  endtask

  task automatic test_reset_mid();
    step();
    do_reset(1);
    req_valid_in   = 4'b0100;
    req_addr_in[2] = 32'h0000_2222;
    sample();
    checks++;
    if (req_ready_out !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b, required 0100", req_ready_out); end
    step();
    req_valid_in = '0;
    sample();
    checks += 2;
    if (msg_valid_out !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b, required 1", msg_valid_out); end
    if (msg_out !== {32'h0000_2222, 4'h2}) begin errors++; $display("FAIL mid_msg: got %h, required %h", msg_out, {32'h0000_2222, 4'h2}); end
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    sample();
    checks += 3;
    if (msg_valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", msg_valid_out); end
    if (pending_out !== '0) begin errors++; $display("FAIL mid_rst_pending: got %b, required 0", pending_out); end
    if (msg_out !== '0) begin errors++; $display("FAIL mid_rst_msg: got %h, required 0", msg_out); end
    // rr_ptr back at 0 means requester 1 beats requester 3.
    step();
    req_valid_in   = 4'b1010;
    req_addr_in[1] = 32'h0000_1111;
    req_addr_in[3] = 32'h0000_3333;
    sample();
    checks++;
    if (req_ready_out !== 4'b0010) begin errors++; $display("FAIL mid_rrptr: got %b, required 0010", req_ready_out); end
    exp_msg_q.push_back({32'h0000_1111, 4'h1});
    step();
    req_valid_in = '0;
    msg_ready_in = 1'b1;
    step();
    msg_ready_in = 1'b0;
    drive_resp(4'h1, 32'hAAAA_0001, 1'b1);
    step();
    resp_valid_in = 1'b0;
    sample();
  endtask

  task automatic test_simultaneous();
    step();
    req_valid_in   = 4'b0001;
    req_addr_in[0] = 32'h0000_5000;
    sample();
    checks++;
    if (req_ready_out !== 4'b0001) begin errors++; $display("FAIL sim_first: got %b, required 0001", req_ready_out); end
    exp_msg_q.push_back({32'h0000_5000, 4'h0});
    step();
    req_valid_in = '0;
    msg_ready_in = 1'b1;
    step();
    msg_ready_in   = 1'b0;
    req_valid_in   = 4'b0001;
    req_addr_in[0] = 32'h0000_5004;
    drive_resp(4'h0, 32'h0000_0050, 1'b1);
    sample();
    checks++;
    if (req_ready_out !== '0) begin errors++; $display("FAIL sim_same_cycle: got %b, required 0", req_ready_out); end
    step();
    resp_valid_in = 1'b0;
    sample();
    checks++;
    if (req_ready_out !== 4'b0001) begin errors++; $display("FAIL sim_next_cycle: got %b, required 0001", req_ready_out); end
    exp_msg_q.push_back({32'h0000_5004, 4'h0});
    step();
    req_valid_in = '0;
    msg_ready_in = 1'b1;
    step();
    msg_ready_in = 1'b0;
    drive_resp(4'h0, 32'h0000_0051, 1'b1);
    step();
    resp_valid_in = 1'b0;
    sample();
  endtask

`ifdef MSG_ROUTER_ARB_PERF_EN
  task automatic test_perf();
    step();
    do_reset(1);
    sample();
    checks++;
    if (grant_count_out !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d, required 0", grant_count_out); end
    for (int i = 0; i < 10; i++) begin
      step();
      req_valid_in = NUM_REQ'(1) << (i % NUM_REQ);
      req_addr_in[i % NUM_REQ] = 32'h0000_B000 + DATA_SIZE'(i);
      exp_msg_q.push_back({32'h0000_B000 + DATA_SIZE'(i), PROC_BITS'(i % NUM_REQ)});
      step();
      req_valid_in = '0;
      msg_ready_in = 1'b1;
      step();
      msg_ready_in = 1'b0;
      drive_resp(PROC_BITS'(i % NUM_REQ), DATA_SIZE'(i), 1'b1);
      step();
      resp_valid_in = 1'b0;
    end
    sample();
    checks++;
    if (grant_count_out !== 32'd10) begin errors++; $display("FAIL perf_count: got %0d, required 10", grant_count_out); end
    $display("perf count %0d", grant_count_out);
  endtask
`endif

  initial begin
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_simultaneous();
`ifdef MSG_ROUTER_ARB_PERF_EN
    test_perf();
`endif
    step();
    sample();
    checks += 2;
    if (exp_msg_q.size() != 0) begin errors++; $display("FAIL msg_scoreboard_empty: got %0d left, required 0", exp_msg_q.size()); end
    if (exp_rv_q.size() != 0) begin errors++; $display("FAIL resp_scoreboard_empty: got %0d left, required 0", exp_rv_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
